video_timing_ctrl: RTL and testbench
====================================

# video_timing_ctrl

Video timing controller and test-pattern scheduler for the HDMI output path. It generates horizontal and vertical sync, data-enable and pixel coordinates for the downstream pattern/pixel-data block. It also sequences which test pattern that block draws, advancing automatically every N frames or on request. It sits between the pixel clock domain root and the pixel-data generator and the MS7210 transmitter interface.

## Interface
- `H_SYNC`, 44: hsync width, pixels
- `H_BACK`, 148: horizontal back porch
- `H_DISP`, 1920: active pixels per line
- `H_FRONT`, 88: horizontal front porch
- `V_SYNC`, 5: vsync width, lines
- `V_BACK`, 36: vertical back porch
- `V_DISP`, 1080: active lines
- `V_FRONT`, 4: vertical front porch
- `PATTERN_NUM`, 5: number of patterns, 1..8
- `FRAMES_PER_PATTERN`, 120: frames per pattern in auto mode, ≥1
- `pixel_clk` in 1: pixel clock, sole clock
- `sys_rst_n` in 1: reset, asynchronous assert, active-low
- `pattern_auto` in 1: 1 = auto-advance pattern, level
- `pattern_next` in 1: single-cycle request to advance pattern, already synchronous to `pixel_clk`
- `video_hs` out 1: hsync, active-high
- `video_vs` out 1: vsync, active-high
- `video_de` out 1: active-video enable
- `pixel_req` out 1: coordinate-valid strobe, leads `video_de` by one cycle
- `pixel_xpos` out 13: active column for `pixel_req`, 0 when idle
- `pixel_ypos` out 13: active row for `pixel_req`, 0 when idle
- `frame_start` out 1: one-cycle pulse at first cycle of each frame
- `pattern_sel` out 3: current pattern index, 0..PATTERN_NUM-1

## Operation
- H_TOTAL = sum of H_* parameters (2200 by default); V_TOTAL = sum of V_* parameters (1125 by default).
- `h_cnt` (13b) counts 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` (13b) increments when `h_cnt` wraps and itself wraps at V_TOTAL-1.
- Decodes:
  - hs = `h_cnt` < H_SYNC
  - vs = `v_cnt` < V_SYNC
  - v_act = `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP)
  - de = v_act and `h_cnt` in [HA, HA+H_DISP), where HA = H_SYNC+H_BACK
  - req = v_act and `h_cnt` in [HA-1, HA+H_DISP-1)
- All outputs are registered from these decodes.
- `pixel_xpos` = `h_cnt`-(HA-1) while req, else 0.
- `pixel_ypos` = `v_cnt`-(V_SYNC+V_BACK) while req, else 0.
- `frame_start` pulses when `h_cnt`=0 and `v_cnt`=0.
- Pattern scheduler, a two-state FSM:
  - HOLD: `frame_cnt` increments on each `frame_start` while `pattern_auto`=1.
  - HOLD → ADVANCE when `frame_cnt` reaches FRAMES_PER_PATTERN-1 on a `frame_start`, or on `pattern_next`.
  - ADVANCE: `pattern_sel` increments, wrapping PATTERN_NUM-1 → 0; `frame_cnt` clears to 0; return to HOLD next cycle.
- Boundary rules:
  - A `pattern_next` coinciding with an auto advance advances exactly once.
  - A `pattern_next` arriving while in ADVANCE is ignored.
  - `pattern_auto`=0 freezes `frame_cnt`; manual advance still works.
  - Clearing `pattern_auto` does not clear `frame_cnt`.

## Timing
- Reset (async, any time mid-frame): `h_cnt`, `v_cnt`, `frame_cnt`, `pattern_sel` = 0; state HOLD; all outputs 0.
- First rising edge after reset release registers the `h_cnt`=0, `v_cnt`=0 decode, so `video_hs`, `video_vs` and `frame_start` go to 1.
- Output latency: one cycle from counter value to output.
- `pixel_req` at cycle t ⇒ `video_de` at t+1. The pixel-data block registers its result, so its data is valid at t+1, aligned with `video_de`.
- `pattern_sel` changes two cycles after the triggering `frame_start` or `pattern_next` edge.
- Every frame is exactly H_TOTAL×V_TOTAL cycles.
- Per frame: `video_de` is high for H_DISP×V_DISP cycles; `pixel_req` is high for the same count.
- `video_hs` and `video_de` are never both high; `video_vs` and `video_de` are never both high.

## Structure
- Shared package `video_timing_pkg` holds:
  - 1080p60 timing constants;
  - 720p60 timing constants (40/220/1280/110, 5/20/720/5);
  - coordinate width constant 13;
  - pattern-index width 3.
- One natural sub-module, `pattern_sched`: the FSM plus `frame_cnt` and `pattern_sel`, driven by `frame_start`.
- Counters and decodes stay in the top level.

## Test plan
- Reset release, default parameters, run 2 frames:
  - `frame_start` period is 2,475,000 cycles;
  - `video_hs` high 44 cycles per line;
  - `video_vs` high 5×2200 cycles per frame.
- Active window: first `pixel_req` occurs at `h_cnt`=191, `v_cnt`=41 with xpos=0, ypos=0; `video_de` rises next cycle. Last `pixel_req` has xpos=1919, ypos=1079.
- Small parameters (2/2/8/2, 1/1/4/1, FRAMES_PER_PATTERN=3, PATTERN_NUM=5), `pattern_auto`=1 for 16 frames: `pattern_sel` sequence is 0,1,2,3,4,0 with 3 frames per step.
- `pattern_auto`=0 with `pattern_next` pulsed 6 times: `pattern_sel` = 1,2,3,4,0,1; no change from frames alone.
- `pattern_next` in the same cycle as an auto-advance `frame_start`: `pattern_sel` increments by exactly 1.
- Assert `sys_rst_n`=0 mid-line at `h_cnt`=1000: all outputs are 0 immediately, without waiting for a clock edge. After release, the timing restarts from `h_cnt`=0 and `pattern_sel`=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// ----------------------------------------------------------------------------
// video_timing_pkg: raster timing presets, coordinate widths and scheduler states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package video_timing_pkg;

    localparam int COORD_W = 13;
    localparam int PAT_W   = 3;

    // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
    localparam int H1080_SYNC  = 44;
    localparam int H1080_BACK  = 148;
    localparam int H1080_DISP  = 1920;
    localparam int H1080_FRONT = 88;
    localparam int V1080_SYNC  = 5;
    localparam int V1080_BACK  = 36;
    localparam int V1080_DISP  = 1080;
    localparam int V1080_FRONT = 4;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
    localparam int H720_SYNC   = 40;
    localparam int H720_BACK   = 220;
    localparam int H720_DISP   = 1280;
    localparam int H720_FRONT  = 110;
    localparam int V720_SYNC   = 5;
    localparam int V720_BACK   = 20;
    localparam int V720_DISP   = 720;
    localparam int V720_FRONT  = 5;

    typedef enum logic [0:0] {
        SCHED_HOLD    = 1'b0,
        SCHED_ADVANCE = 1'b1
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_sched.sv
// ----------------------------------------------------------------------------
// pattern_sched: steps the test-pattern index every N frames or on request
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pattern_sched
    import video_timing_pkg::*;
#(
    parameter int PATTERN_NUM        = 5,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic             pixel_clk,
    input  logic             sys_rst_n,
    input  logic             frame_start,
    input  logic             pattern_auto,
    input  logic             pattern_next,
    output logic [PAT_W-1:0] pattern_sel
);

    localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FC_W-1:0]  c_frame_last = FC_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [PAT_W-1:0] c_pat_last   = PAT_W'(PATTERN_NUM - 1);

    sched_state_t    r_state;
    logic [FC_W-1:0] r_frame_cnt;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= SCHED_HOLD;
            r_frame_cnt <= '0;
            pattern_sel <= '0;
        end else begin
            case (r_state)
                SCHED_HOLD: begin
                    // A manual request in the same cycle as the auto rollover still yields one step
                    if (frame_start && pattern_auto && (r_frame_cnt == c_frame_last)) begin
                        r_state <= SCHED_ADVANCE;
                    end else begin
                        if (frame_start && pattern_auto) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                        if (pattern_next) begin
                            r_state <= SCHED_ADVANCE;
                        end
                    end
                end
                SCHED_ADVANCE: begin
                    pattern_sel <= (pattern_sel == c_pat_last) ? '0 : pattern_sel + 1'b1;
                    r_frame_cnt <= '0;
                    r_state     <= SCHED_HOLD;
                end
                default: begin
                    r_state <= SCHED_HOLD;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_ctrl.sv
// ----------------------------------------------------------------------------
// video_timing_ctrl: raster counters, sync/DE/coordinate decode, pattern scheduling
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_SYNC             = H1080_SYNC,
    parameter int H_BACK             = H1080_BACK,
    parameter int H_DISP             = H1080_DISP,
    parameter int H_FRONT            = H1080_FRONT,
    parameter int V_SYNC             = V1080_SYNC,
    parameter int V_BACK             = V1080_BACK,
    parameter int V_DISP             = V1080_DISP,
    parameter int V_FRONT            = V1080_FRONT,
    parameter int PATTERN_NUM        = 5,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic               pixel_clk,
    input  logic               sys_rst_n,
    input  logic               pattern_auto,
    input  logic               pattern_next,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output logic               pixel_req,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               frame_start,
    output logic [PAT_W-1:0]   pattern_sel
);

    localparam logic [COORD_W-1:0] c_h_last = COORD_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [COORD_W-1:0] c_v_last = COORD_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [COORD_W-1:0] c_h_sync = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] c_v_sync = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] c_ha     = COORD_W'(H_SYNC + H_BACK);
    localparam logic [COORD_W-1:0] c_ha_m1  = COORD_W'(H_SYNC + H_BACK - 1);
    localparam logic [COORD_W-1:0] c_he     = COORD_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [COORD_W-1:0] c_he_m1  = COORD_W'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [COORD_W-1:0] c_va     = COORD_W'(V_SYNC + V_BACK);
    localparam logic [COORD_W-1:0] c_ve     = COORD_W'(V_SYNC + V_BACK + V_DISP);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    logic w_hs;
    logic w_vs;
    logic w_v_act;
    logic w_de;
    logic w_req;
    logic w_frame_start;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Request window sits one column ahead of DE so the pixel source can register its data
    always_comb begin
        w_hs          = (r_h_cnt < c_h_sync);
        w_vs          = (r_v_cnt < c_v_sync);
        w_v_act       = (r_v_cnt >= c_va) && (r_v_cnt < c_ve);
        w_de          = w_v_act && (r_h_cnt >= c_ha) && (r_h_cnt < c_he);
        w_req         = w_v_act && (r_h_cnt >= c_ha_m1) && (r_h_cnt < c_he_m1);
        w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= 1'b0;
            video_vs    <= 1'b0;
            video_de    <= 1'b0;
            pixel_req   <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= w_hs;
            video_vs    <= w_vs;
            video_de    <= w_de;
            pixel_req   <= w_req;
            pixel_xpos  <= w_req ? (r_h_cnt - c_ha_m1) : '0;
            pixel_ypos  <= w_req ? (r_v_cnt - c_va) : '0;
            frame_start <= w_frame_start;
        end
    end

    pattern_sched #(
        .PATTERN_NUM        (PATTERN_NUM),
        .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN)
    ) u_pattern_sched (
        .pixel_clk    (pixel_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_start  (frame_start),
        .pattern_auto (pattern_auto),
        .pattern_next (pattern_next),
        .pattern_sel  (pattern_sel)
    );

endmodule

`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_video_timing_ctrl: randomized self-checking bench against a raster/pattern model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_video_timing_ctrl;

    localparam int HS = 2, HB = 2, HD = 8, HF = 2;
    localparam int VS = 1, VB = 1, VD = 4, VF = 1;
    localparam int FPP = 3, PN = 5;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        req;
        logic        fs;
        logic [12:0] x;
        logic [12:0] y;
    } vid_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pat_auto = 1'b0;
    logic        pat_next = 1'b0;
    logic        video_hs, video_vs, video_de, pixel_req, frame_start;
    logic [12:0] pixel_xpos, pixel_ypos;
    logic [2:0]  pattern_sel;
    vid_t        obs;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: edges since reset release, pattern index, frame count, last accepted request edge
    int   n_edges = 0;
    int   m_pat = 0;
    int   m_fcnt = 0;
    int   last_acc = -10;
    int   m_e;
    vid_t m_cur;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .PATTERN_NUM(PN), .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .pixel_clk    (clk),
        .sys_rst_n    (rst_n),
        .pattern_auto (pat_auto),
        .pattern_next (pat_next),
        .video_hs     (video_hs),
        .video_vs     (video_vs),
        .video_de     (video_de),
        .pixel_req    (pixel_req),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .frame_start  (frame_start),
        .pattern_sel  (pattern_sel)
    );

    assign obs = {video_hs, video_vs, video_de, pixel_req, frame_start, pixel_xpos, pixel_ypos};

    // Outputs seen after n clock edges describe raster position n-1 of an HT x VT frame
    function automatic vid_t exp_vid(input int n);
        vid_t r;
        int   p, h, v;
        bit   act;
        r = '0;
        if (n < 1) return r;
        p = (n - 1) % FRAME;
        h = p % HT;
        v = p / HT;
        act = (v >= VS + VB) && (v < VS + VB + VD);
        r.hs  = (h < HS);
        r.vs  = (v < VS);
        r.fs  = (p == 0);
        r.req = act && (h >= HS + HB - 1) && (h < HS + HB + HD - 1);
        r.de  = act && (h >= HS + HB) && (h < HS + HB + HD);
        if (r.req) begin
            r.x = 13'(h - (HS + HB - 1));
            r.y = 13'(v - (VS + VB));
        end
        return r;
    endfunction

    // A request accepted at edge e shows on pattern_sel after edge e+1; requests at e+1 are dropped
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edges  = 0;
            m_pat    = 0;
            m_fcnt   = 0;
            last_acc = -10;
        end else begin
            m_cur = exp_vid(n_edges);
            m_e   = n_edges + 1;
            if (last_acc == m_e - 1) begin
                m_pat  = (m_pat + 1) % PN;
                m_fcnt = 0;
            end else if ((m_cur.fs && pat_auto && m_fcnt == FPP - 1) || pat_next) begin
                last_acc = m_e;
            end else if (m_cur.fs && pat_auto) begin
                m_fcnt = m_fcnt + 1;
            end
            n_edges = m_e;
        end
    end

    task automatic do_reset(input logic auto_val);
        @(negedge clk);
        #2 rst_n = 1'b0;
        pat_auto = auto_val;
        pat_next = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vid_t e1;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs); else n_pass++;
        n_chk++; if (pattern_sel !== 3'd0) $display("FAIL reset_pattern: got %0d want 0", pattern_sel); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e1 = '0; e1.hs = 1'b1; e1.vs = 1'b1; e1.fs = 1'b1;
        n_chk++; if (obs !== e1) $display("FAIL first_edge: got %h want %h", obs, e1); else n_pass++;
    endtask

    task automatic test_timing();
        int   hs_c = 0, vs_c = 0, de_c = 0, rq_c = 0, ovl = 0, last_fs = -1, first_rq = -1;
        logic [12:0] lx = '0, ly = '0;
        vid_t e;
        while (n_edges <= 2 * FRAME) begin
            e = exp_vid(n_edges);
            n_chk++; if (obs !== e) $display("FAIL raster n=%0d: got %h want %h", n_edges, obs, e); else n_pass++;
            hs_c += int'(video_hs); vs_c += int'(video_vs);
            de_c += int'(video_de); rq_c += int'(pixel_req);
            if (video_de && (video_hs || video_vs)) ovl++;
            if (frame_start) begin
                if (last_fs >= 0) begin
                    n_chk++; if (n_edges - last_fs != FRAME) $display("FAIL fs_period: got %0d want %0d", n_edges - last_fs, FRAME); else n_pass++;
                end
                last_fs = n_edges;
            end
            if (pixel_req && first_rq < 0) begin
                first_rq = n_edges;
                n_chk++;
                if (n_edges != 1 + (VS + VB) * HT + (HS + HB - 1) || pixel_xpos != 0 || pixel_ypos != 0)
                    $display("FAIL first_req: got n=%0d x=%0d y=%0d want n=%0d x=0 y=0",
                             n_edges, pixel_xpos, pixel_ypos, 1 + (VS + VB) * HT + (HS + HB - 1));
                else n_pass++;
            end
            if (first_rq >= 0 && n_edges == first_rq + 1) begin
                n_chk++; if (video_de !== 1'b1) $display("FAIL de_follows_req: got %b want 1", video_de); else n_pass++;
            end
            if (pixel_req) begin lx = pixel_xpos; ly = pixel_ypos; end
            @(negedge clk);
        end
        n_chk++; if (hs_c != 2 * VT * HS) $display("FAIL hs_count: got %0d want %0d", hs_c, 2 * VT * HS); else n_pass++;
        n_chk++; if (vs_c != 2 * VS * HT) $display("FAIL vs_count: got %0d want %0d", vs_c, 2 * VS * HT); else n_pass++;
        n_chk++; if (de_c != 2 * HD * VD) $display("FAIL de_count: got %0d want %0d", de_c, 2 * HD * VD); else n_pass++;
        n_chk++; if (rq_c != 2 * HD * VD) $display("FAIL req_count: got %0d want %0d", rq_c, 2 * HD * VD); else n_pass++;
        n_chk++; if (ovl != 0) $display("FAIL sync_de_overlap: got %0d want 0", ovl); else n_pass++;
        n_chk++; if (lx != 13'(HD - 1) || ly != 13'(VD - 1))
            $display("FAIL last_req: got x=%0d y=%0d want x=%0d y=%0d", lx, ly, HD - 1, VD - 1); else n_pass++;
    endtask

    task automatic test_auto_advance();
        int   chg_n[$];
        int   chg_v[$];
        int   want_v[5] = '{1, 2, 3, 4, 0};
        logic [2:0] prev;
        do_reset(1'b1);
        prev = pattern_sel;
        while (n_edges <= 16 * FRAME) begin
            n_chk++; if (pattern_sel !== 3'(m_pat)) $display("FAIL auto_sel n=%0d: got %0d want %0d", n_edges, pattern_sel, m_pat); else n_pass++;
            if (pattern_sel !== prev) begin chg_n.push_back(n_edges); chg_v.push_back(int'(pattern_sel)); end
            prev = pattern_sel;
            @(negedge clk);
        end
        n_chk++; if (chg_n.size() != 5) $display("FAIL auto_steps: got %0d want 5", chg_n.size()); else n_pass++;
        if (chg_n.size() == 5) begin
            n_chk++; if (chg_n[0] != 2 * FRAME + 3) $display("FAIL auto_first_step: got n=%0d want n=%0d", chg_n[0], 2 * FRAME + 3); else n_pass++;
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (chg_v[i] != want_v[i]) $display("FAIL auto_seq[%0d]: got %0d want %0d", i, chg_v[i], want_v[i]); else n_pass++;
                if (i > 0) begin
                    n_chk++; if (chg_n[i] - chg_n[i-1] != FPP * FRAME)
                        $display("FAIL auto_spacing[%0d]: got %0d want %0d", i, chg_n[i] - chg_n[i-1], FPP * FRAME); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_manual_advance();
        int want_v[6] = '{1, 2, 3, 4, 0, 1};
        int old_v;
        do_reset(1'b0);
        repeat (3 * FRAME) @(negedge clk);
        n_chk++; if (pattern_sel !== 3'd0) $display("FAIL manual_frozen: got %0d want 0", pattern_sel); else n_pass++;
        old_v = 0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(3, 20)) @(negedge clk);
            pat_next = 1'b1;
            @(negedge clk);
            pat_next = 1'b0;
            n_chk++; if (pattern_sel !== 3'(old_v)) $display("FAIL manual_early[%0d]: got %0d want %0d", i, pattern_sel, old_v); else n_pass++;
            @(negedge clk);
            n_chk++; if (pattern_sel !== 3'(want_v[i])) $display("FAIL manual_step[%0d]: got %0d want %0d", i, pattern_sel, want_v[i]); else n_pass++;
            old_v = want_v[i];
        end
    endtask

    task automatic test_back_to_back();
        int fs_seen = 0;
        int guard = 0;
        do_reset(1'b1);
        while (fs_seen < FPP && guard < 4 * FRAME) begin
            if (exp_vid(n_edges).fs) fs_seen++;
            if (fs_seen < FPP) begin @(negedge clk); guard++; end
        end
        n_chk++; if (fs_seen != FPP) $display("FAIL coincide_setup: got %0d frame starts want %0d", fs_seen, FPP); else n_pass++;
        pat_next = 1'b1;
        @(negedge clk);
        pat_next = 1'b0;
        @(negedge clk);
        n_chk++; if (pattern_sel !== 3'd1) $display("FAIL coincide_step: got %0d want 1", pattern_sel); else n_pass++;
        repeat (6) @(negedge clk);
        n_chk++; if (pattern_sel !== 3'd1) $display("FAIL coincide_once: got %0d want 1", pattern_sel); else n_pass++;
        pat_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pat_next = 1'b0;
        n_chk++; if (pattern_sel !== 3'd2) $display("FAIL held_next_step: got %0d want 2", pattern_sel); else n_pass++;
        repeat (6) @(negedge clk);
        n_chk++; if (pattern_sel !== 3'd2) $display("FAIL held_next_once: got %0d want 2", pattern_sel); else n_pass++;
    endtask

    task automatic test_random();
        vid_t e;
        pat_auto = 1'b1;
        repeat (2000) begin
            e = exp_vid(n_edges);
            n_chk++; if (obs !== e) $display("FAIL rand_raster n=%0d: got %h want %h", n_edges, obs, e); else n_pass++;
            n_chk++; if (pattern_sel !== 3'(m_pat)) $display("FAIL rand_sel n=%0d: got %0d want %0d", n_edges, pattern_sel, m_pat); else n_pass++;
            if ($urandom_range(0, 199) == 0) pat_auto = ~pat_auto;
            pat_next = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        pat_next = 1'b0;
    endtask

    task automatic test_reset_midline();
        vid_t e;
        int   guard = 0;
        pat_auto = 1'b0;
        for (int i = 0; i < 2 && m_pat == 0; i++) begin
            pat_next = 1'b1;
            @(negedge clk);
            pat_next = 1'b0;
            repeat (3) @(negedge clk);
        end
        while (!((n_edges % HT) == 7 && ((n_edges % FRAME) / HT) == VS + VB + 1) && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_chk++; if (guard >= 2 * FRAME) $display("FAIL midline_setup: got timeout want position"); else n_pass++;
        n_chk++; if (obs === '0 || pattern_sel === 3'd0)
            $display("FAIL midline_pre: got outputs %h sel %0d want nonzero", obs, pattern_sel); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (obs !== '0) $display("FAIL midline_async: got %h want 0", obs); else n_pass++;
        n_chk++; if (pattern_sel !== 3'd0) $display("FAIL midline_sel: got %0d want 0", pattern_sel); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (HT) begin
            e = exp_vid(n_edges);
            n_chk++; if (obs !== e) $display("FAIL restart n=%0d: got %h want %h", n_edges, obs, e); else n_pass++;
            n_chk++; if (pattern_sel !== 3'd0) $display("FAIL restart_sel: got %0d want 0", pattern_sel); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_auto_advance();
        test_manual_advance();
        test_back_to_back();
        test_random();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
